// File: rtl/pe_tile_pkg.sv
// Shared constants for the parametrised PE tile: config block ids, switch-box nibble layout
// and a constant-foldable clog2.
package pe_tile_pkg;

  localparam logic [7:0] LB_ID  = 8'd0;
  localparam logic [7:0] CB0_ID = 8'd1;
  localparam logic [7:0] CB1_ID = 8'd2;
  localparam logic [7:0] SB_ID  = 8'd3;

  // One switch-box output per nibble: [1:0] source, [2] register enable, [3] reserved.
  localparam int SB_NIB_W    = 4;
  localparam int SB_SRC_LSB  = 0;
  localparam int SB_SRC_W    = 2;
  localparam int SB_REG_BIT  = 2;
  localparam int SB_CFG_W    = 3;
  localparam int SB_PER_WORD = 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sb_track_mux.sv
// One switch-box output track: 4:1 source select with an optional output flop.
module sb_track_mux (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] src_in,
  input  logic [1:0] src_sel,
  input  logic       reg_en,
  output logic       track_out
);

  logic sel_d;
  logic q_reg;

  assign sel_d = src_in[src_sel];

  // The flop samples every cycle so enabling it never exposes a stale value for long.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg <= 1'b0;
    end else begin
      q_reg <= sel_d;
    end
  end

  assign track_out = reg_en ? q_reg : sel_d;

endmodule

// File: rtl/pe_tile_param.sv
// One fabric cell: two connection boxes feeding a 2-input LUT, a switch box driving every
// output track, and a strobe/ack config bus that writes and reads the tile's config words.
module pe_tile_param
  import pe_tile_pkg::*;
#(
  parameter int NUM_TRACKS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             tile_id,
  input  logic [31:0]             config_addr,
  input  logic [31:0]             config_data,
  input  logic                    config_we,
  input  logic                    config_re,
  output logic [31:0]             config_rdata,
  output logic                    config_ack,
  output logic                    config_err,
  input  logic [4*NUM_TRACKS-1:0] in_wires,
  output logic [4*NUM_TRACKS-1:0] out_wires
);

  localparam int TRK      = 4 * NUM_TRACKS;
  localparam int SELW     = clog2(TRK);
  localparam int SB_WORDS = (TRK + SB_PER_WORD - 1) / SB_PER_WORD;

  localparam logic [7:0]    SB_WORDS_W = 8'(SB_WORDS);
  localparam logic [SELW:0] TRK_LIM    = (SELW + 1)'(TRK);

  // ---------------------------------------------------------------- config decode
  logic [7:0] cfg_block;
  logic [7:0] cfg_word;
  logic       tile_hit;
  logic       strobe_ok;
  logic       addr_bad;
  logic       wr_en;
  logic       rd_en;
  logic       cfg_unused;

  assign cfg_block  = config_addr[15:8];
  assign cfg_word   = config_addr[7:0];
  assign tile_hit   = (config_addr[31:16] == tile_id);
  assign strobe_ok  = tile_hit && (config_we || config_re);
  assign cfg_unused = ^config_data;

  always_comb begin
    addr_bad = 1'b0;
    case (cfg_block)
      LB_ID, CB0_ID, CB1_ID: addr_bad = (cfg_word != 8'd0);
      SB_ID:                 addr_bad = (cfg_word >= SB_WORDS_W);
      default:               addr_bad = 1'b1;
    endcase
  end

  // A simultaneous read is dropped in favour of the write.
  assign wr_en = strobe_ok && config_we && !addr_bad;
  assign rd_en = strobe_ok && !config_we && config_re && !addr_bad;

  // ---------------------------------------------------------------- register file
  logic [4:0]                        lb_cfg_reg;
  logic [SELW-1:0]                   cb0_sel_reg;
  logic [SELW-1:0]                   cb1_sel_reg;
  logic [TRK-1:0][SB_CFG_W-1:0]      sb_cfg_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lb_cfg_reg  <= '0;
      cb0_sel_reg <= '0;
      cb1_sel_reg <= '0;
      sb_cfg_reg  <= '0;
    end else if (wr_en) begin
      case (cfg_block)
        LB_ID:  lb_cfg_reg  <= config_data[4:0];
        CB0_ID: cb0_sel_reg <= config_data[SELW-1:0];
        CB1_ID: cb1_sel_reg <= config_data[SELW-1:0];
        SB_ID: begin
          for (int k = 0; k < TRK; k++) begin
            if (cfg_word == 8'(k / SB_PER_WORD)) begin
              sb_cfg_reg[k] <= config_data[(k % SB_PER_WORD) * SB_NIB_W +: SB_CFG_W];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- readback
  logic [31:0] sb_rword;
  logic [31:0] rd_word;

  always_comb begin
    sb_rword = '0;
    for (int k = 0; k < TRK; k++) begin
      if (cfg_word == 8'(k / SB_PER_WORD)) begin
        sb_rword[(k % SB_PER_WORD) * SB_NIB_W +: SB_CFG_W] = sb_cfg_reg[k];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (cfg_block)
      LB_ID:   rd_word[4:0]      = lb_cfg_reg;
      CB0_ID:  rd_word[SELW-1:0] = cb0_sel_reg;
      CB1_ID:  rd_word[SELW-1:0] = cb1_sel_reg;
      SB_ID:   rd_word           = sb_rword;
      default: rd_word           = '0;
    endcase
  end

  logic        ack_reg;
  logic        err_reg;
  logic [31:0] rdata_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      ack_reg   <= strobe_ok;
      err_reg   <= strobe_ok && addr_bad;
      rdata_reg <= rd_en ? rd_word : '0;
    end
  end

  assign config_ack   = ack_reg;
  assign config_err   = err_reg;
  assign config_rdata = rdata_reg;

  // ---------------------------------------------------------------- logic block
  logic       op_0;
  logic       op_1;
  logic [1:0] lut_idx;
  logic       lut_out;
  logic       lut_reg;
  logic       pe_out;

  // Selects past the last track read as 0 rather than aliasing onto a real wire.
  assign op_0    = ({1'b0, cb0_sel_reg} < TRK_LIM) ? in_wires[cb0_sel_reg] : 1'b0;
  assign op_1    = ({1'b0, cb1_sel_reg} < TRK_LIM) ? in_wires[cb1_sel_reg] : 1'b0;
  assign lut_idx = {op_1, op_0};
  assign lut_out = lb_cfg_reg[lut_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lut_reg <= 1'b0;
    end else begin
      lut_reg <= lut_out;
    end
  end

  assign pe_out = lb_cfg_reg[4] ? lut_reg : lut_out;

  // ---------------------------------------------------------------- switch box
  logic [TRK-1:0] track_out;

  genvar gi;
  generate
    for (gi = 0; gi < TRK; gi++) begin : g_track
      localparam int S  = gi / NUM_TRACKS;
      localparam int T  = gi % NUM_TRACKS;
      // The three other sides in ascending order, skipping this output's own side.
      localparam int O0 = (S > 0) ? 0 : 1;
      localparam int O1 = (S > 1) ? 1 : 2;
      localparam int O2 = (S > 2) ? 2 : 3;

      sb_track_mux u_mux (
        .clk       (clk),
        .reset     (reset),
        .src_in    ({pe_out,
                     in_wires[O2 * NUM_TRACKS + T],
                     in_wires[O1 * NUM_TRACKS + T],
                     in_wires[O0 * NUM_TRACKS + T]}),
        .src_sel   (sb_cfg_reg[gi][SB_SRC_LSB +: SB_SRC_W]),
        .reg_en    (sb_cfg_reg[gi][SB_REG_BIT]),
        .track_out (track_out[gi])
      );
    end
  endgenerate

  // Combinational paths are forced low while reset is held so the fabric sees a quiet tile.
  assign out_wires = track_out & {TRK{reset}};

endmodule

// File: tb/tb_pe_tile_param.sv
// Directed bench for pe_tile_param: config responses are checked by a scoreboard monitor,
// track behaviour by direct sampling one time unit after the clock edge.
module tb_pe_tile_param;

  localparam int NUM_TRACKS = 4;
  localparam int TRK        = 4 * NUM_TRACKS;
  localparam logic [15:0] MY_TILE = 16'h0005;

  logic           clk;
  logic           reset;
  logic [15:0]    tile_id;
  logic [31:0]    config_addr;
  logic [31:0]    config_data;
  logic           config_we;
  logic           config_re;
  logic [31:0]    config_rdata;
  logic           config_ack;
  logic           config_err;
  logic [TRK-1:0] in_wires;
  logic [TRK-1:0] out_wires;

  int n_chk  = 0;
  int n_fail = 0;

  logic [32:0] exp_q[$];

  pe_tile_param #(.NUM_TRACKS(NUM_TRACKS)) dut (
    .clk          (clk),
    .reset        (reset),
    .tile_id      (tile_id),
    .config_addr  (config_addr),
    .config_data  (config_data),
    .config_we    (config_we),
    .config_re    (config_re),
    .config_rdata (config_rdata),
    .config_ack   (config_ack),
    .config_err   (config_err),
    .in_wires     (in_wires),
    .out_wires    (out_wires)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk_addr(input logic [15:0] t, input logic [7:0] b,
                                          input logic [7:0] w);
    return {t, b, w};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("check %s: %h", name, act);
    end
  endtask

  // Scoreboard monitor: every ack pops one expected {err, rdata}.
  always @(negedge clk) begin
    if (config_ack === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL ack_unexpected: got ack err=%b rdata=%h, required no ack", config_err,
                 config_rdata);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({config_err, config_rdata} !== e) begin
          n_fail++;
          $display("FAIL ack_resp: got err=%b rdata=%h, required err=%b rdata=%h", config_err,
                   config_rdata, e[32], e[31:0]);
        end else begin
          $display("ack: err=%b rdata=%h", config_err, config_rdata);
        end
      end
    end
  end

  // Strobe tasks are entered 1 time unit after a rising edge and return likewise.
  task automatic cfg_wr(input logic [31:0] a, input logic [31:0] d, input bit accepted,
                        input bit exp_err);
    config_addr = a;
    config_data = d;
    config_we   = 1'b1;
    if (accepted) exp_q.push_back({exp_err, 32'h0});
    $display("write addr=%h data=%h", a, d);
    @(posedge clk); #1;
    config_we = 1'b0;
  endtask

  task automatic cfg_rd(input logic [31:0] a, input bit exp_err, input logic [31:0] exp_data);
    config_addr = a;
    config_re   = 1'b1;
    exp_q.push_back({exp_err, exp_data});
    $display("read  addr=%h", a);
    @(posedge clk); #1;
    config_re = 1'b0;
  endtask

  task automatic cfg_wr_rd(input logic [31:0] a, input logic [31:0] d);
    config_addr = a;
    config_data = d;
    config_we   = 1'b1;
    config_re   = 1'b1;
    exp_q.push_back({1'b0, 32'h0});
    $display("write+read addr=%h data=%h", a, d);
    @(posedge clk); #1;
    config_we = 1'b0;
    config_re = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    tile_id     = MY_TILE;
    config_addr = '0;
    config_data = '0;
    config_we   = 1'b0;
    config_re   = 1'b0;
    in_wires    = '1;

    // 1: reset state, then LB write/readback
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_side0", 32'(out_wires[3:0]), 32'h0);
    chk("rst_out_all", 32'(out_wires), 32'h0);
    chk("rst_ack", 32'(config_ack), 32'h0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_out", 32'(out_wires), 32'h0000_FFFF);
    cfg_wr(mk_addr(MY_TILE, 8'd0, 8'd0), 32'h0000_001F, 1'b1, 1'b0);
    cfg_rd(mk_addr(MY_TILE, 8'd0, 8'd0), 1'b0, 32'h0000_001F);

    // 2: foreign tile strobe is ignored
    cfg_wr(mk_addr(16'h0006, 8'd0, 8'd0), 32'h0000_0003, 1'b0, 1'b0);
    cfg_rd(mk_addr(MY_TILE, 8'd0, 8'd0), 1'b0, 32'h0000_001F);

    // 3: SB out1 from side 3 track 1, combinational then registered
    in_wires = '0;
    cfg_wr(mk_addr(MY_TILE, 8'd3, 8'd0), 32'h0000_0020, 1'b1, 1'b0);
    chk("sb_comb_low", 32'(out_wires[1]), 32'h0);
    in_wires[13] = 1'b1;
    #1 chk("sb_comb_high", 32'(out_wires[1]), 32'h1);
    in_wires[13] = 1'b0;
    #1 chk("sb_comb_back", 32'(out_wires[1]), 32'h0);
    cfg_wr(mk_addr(MY_TILE, 8'd3, 8'd0), 32'h0000_0060, 1'b1, 1'b0);
    in_wires[13] = 1'b1;
    #1 chk("sb_reg_before", 32'(out_wires[1]), 32'h0);
    @(posedge clk); #1;
    chk("sb_reg_after", 32'(out_wires[1]), 32'h1);
    in_wires[13] = 1'b0;
    #1 chk("sb_reg_hold", 32'(out_wires[1]), 32'h1);

    // 4: CB0=2, CB1=7, AND LUT registered, SB out0 from pe_out
    cfg_wr(mk_addr(MY_TILE, 8'd1, 8'd0), 32'h0000_0002, 1'b1, 1'b0);
    cfg_wr(mk_addr(MY_TILE, 8'd2, 8'd0), 32'h0000_0007, 1'b1, 1'b0);
    cfg_wr(mk_addr(MY_TILE, 8'd0, 8'd0), 32'h0000_0018, 1'b1, 1'b0);
    cfg_wr(mk_addr(MY_TILE, 8'd3, 8'd0), 32'h0000_0063, 1'b1, 1'b0);
    in_wires[2] = 1'b1;
    in_wires[7] = 1'b1;
    #1 chk("pe_reg_before", 32'(out_wires[0]), 32'h0);
    @(posedge clk); #1;
    chk("pe_reg_after", 32'(out_wires[0]), 32'h1);
    in_wires[7] = 1'b0;
    @(posedge clk); #1;
    chk("pe_and_drop", 32'(out_wires[0]), 32'h0);
    cfg_rd(mk_addr(MY_TILE, 8'd2, 8'd0), 1'b0, 32'h0000_0007);

    // 5: out-of-range accesses, reserved bits, write+read collision
    cfg_wr(mk_addr(MY_TILE, 8'd3, 8'd9), 32'hFFFF_FFFF, 1'b1, 1'b1);
    cfg_rd(mk_addr(MY_TILE, 8'd3, 8'd0), 1'b0, 32'h0000_0063);
    cfg_rd(mk_addr(MY_TILE, 8'd4, 8'd0), 1'b1, 32'h0);
    cfg_rd(mk_addr(MY_TILE, 8'd0, 8'd1), 1'b1, 32'h0);
    cfg_rd(mk_addr(MY_TILE, 8'd3, 8'd2), 1'b1, 32'h0);
    cfg_wr(mk_addr(MY_TILE, 8'd3, 8'd1), 32'hFFFF_FFFF, 1'b1, 1'b0);
    cfg_rd(mk_addr(MY_TILE, 8'd3, 8'd1), 1'b0, 32'h7777_7777);
    cfg_wr_rd(mk_addr(MY_TILE, 8'd0, 8'd0), 32'h0000_0008);
    cfg_rd(mk_addr(MY_TILE, 8'd0, 8'd0), 1'b0, 32'h0000_0008);

    // 6: reset between strobe and ack suppresses the ack
    in_wires = '1;
    cfg_wr(mk_addr(MY_TILE, 8'd0, 8'd0), 32'h0000_001F, 1'b0, 1'b0);
    reset = 1'b0;
    #1 chk("rst_mid_ack", 32'(config_ack), 32'h0);
    chk("rst_mid_out", 32'(out_wires), 32'h0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst2_out", 32'(out_wires), 32'h0000_FFFF);
    cfg_rd(mk_addr(MY_TILE, 8'd0, 8'd0), 1'b0, 32'h0);

    repeat (3) @(posedge clk);
    #1 chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
